// File: rtl/eth_pcs_rx_block_sync.sv
// 64b/66b receive front end: gearbox from W_DATA-bit PMA words into 66-bit
// blocks with single-bit slip, followed by the Clause 49 block-lock machine.
module eth_pcs_rx_block_sync #(
  parameter int W_DATA       = 32,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [W_DATA-1:0] i_pma_data,
  output logic              o_block_valid,
  output logic [1:0]        o_block_header,
  output logic [63:0]       o_block_data,
  output logic              o_block_lock,
  output logic              o_slip
);

  localparam int BUF_W  = 132;
  localparam int FILL_W = 8;
  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);

  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(W_DATA);
  localparam logic [FILL_W-1:0] FILL_BLK  = FILL_W'(66);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LIMIT = INV_W'(SH_INVLD_MAX);

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    TEST      = 2'd1,
    SLIP      = 2'd2
  } state_t;

  logic [BUF_W-1:0]  shift_q, shift_d, shift_slip, shift_app, word_ext;
  logic [FILL_W-1:0] fill_q, fill_d, fill_slip, fill_app;
  logic              emit;

  logic              valid_q;
  logic [1:0]        header_q;
  logic [63:0]       data_q;

  state_t            state_q, state_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [CNT_W-1:0]  sh_cnt_q, sh_cnt_d, cnt_inc;
  logic [INV_W-1:0]  sh_invld_cnt_q, sh_invld_cnt_d, inv_inc;
  logic              hdr_valid;

  assign word_ext = BUF_W'(i_pma_data);

  // Bits above fill are always zero, so appending is a plain OR at offset fill.
  always_comb begin
    shift_slip = shift_q;
    fill_slip  = fill_q;
    if (slip_q && (fill_q != '0)) begin
      shift_slip = shift_q >> 1;
      fill_slip  = fill_q - FILL_ONE;
    end
    shift_app = shift_slip | (word_ext << fill_slip);
    fill_app  = fill_slip + FILL_WORD;
    emit      = (fill_app >= FILL_BLK);
    shift_d   = shift_app;
    fill_d    = fill_app;
    if (emit) begin
      shift_d = shift_app >> 66;
      fill_d  = fill_app - FILL_BLK;
    end
  end

  assign hdr_valid = shift_app[0] ^ shift_app[1];
  assign cnt_inc   = sh_cnt_q + CNT_ONE;
  assign inv_inc   = sh_invld_cnt_q + INV_W'(!hdr_valid);

  always_comb begin
    state_d        = state_q;
    lock_d         = lock_q;
    slip_d         = 1'b0;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    case (state_q)
      // LOCK_INIT only holds reset values, so its first block is tested as in TEST.
      LOCK_INIT, TEST: begin
        if (emit) begin
          state_d = TEST;
          if (!lock_q) begin
            if (!hdr_valid) begin
              state_d = SLIP;
            end else if (cnt_inc == CNT_LIMIT) begin
              lock_d         = 1'b1;
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d = cnt_inc;
            end
          end else begin
            if (inv_inc == INV_LIMIT) begin
              lock_d  = 1'b0;
              state_d = SLIP;
            end else if (cnt_inc == CNT_LIMIT) begin
              sh_cnt_d       = '0;
              sh_invld_cnt_d = '0;
            end else begin
              sh_cnt_d       = cnt_inc;
              sh_invld_cnt_d = inv_inc;
            end
          end
        end
      end
      SLIP: begin
        slip_d         = 1'b1;
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
        state_d        = TEST;
      end
      default: state_d = LOCK_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q        <= '0;
      fill_q         <= '0;
      valid_q        <= 1'b0;
      header_q       <= '0;
      data_q         <= '0;
      state_q        <= LOCK_INIT;
      lock_q         <= 1'b0;
      slip_q         <= 1'b0;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
    end else begin
      shift_q        <= shift_d;
      fill_q         <= fill_d;
      valid_q        <= emit;
      if (emit) begin
        header_q <= shift_app[1:0];
        data_q   <= shift_app[65:2];
      end
      state_q        <= state_d;
      lock_q         <= lock_d;
      slip_q         <= slip_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
    end
  end

  assign o_block_valid  = valid_q;
  assign o_block_header = header_q;
  assign o_block_data   = data_q;
  assign o_block_lock   = lock_q;
  assign o_slip         = slip_q;

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Bench for eth_pcs_rx_block_sync: a W_DATA=32 instance driven by scenario
// streams, plus 16/64/66-bit instances fed an aligned reference stream.
module tb_eth_pcs_rx_block_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic [31:0] d32 = '0;
  logic [15:0] d16 = '0;
  logic [63:0] d64 = '0;
  logic [65:0] d66 = '0;

  logic v32, l32, s32, v16, l16, s16, v64, l64, s64, v66, l66, s66;
  logic [1:0]  h32, h16, h64, h66;
  logic [63:0] dt32, dt16, dt64, dt66;

  eth_pcs_rx_block_sync #(.W_DATA(32)) u32 (
    .i_clk(clk), .i_reset(rst), .i_pma_data(d32), .o_block_valid(v32),
    .o_block_header(h32), .o_block_data(dt32), .o_block_lock(l32), .o_slip(s32));
  eth_pcs_rx_block_sync #(.W_DATA(16)) u16 (
    .i_clk(clk), .i_reset(rst), .i_pma_data(d16), .o_block_valid(v16),
    .o_block_header(h16), .o_block_data(dt16), .o_block_lock(l16), .o_slip(s16));
  eth_pcs_rx_block_sync #(.W_DATA(64)) u64 (
    .i_clk(clk), .i_reset(rst), .i_pma_data(d64), .o_block_valid(v64),
    .o_block_header(h64), .o_block_data(dt64), .o_block_lock(l64), .o_slip(s64));
  eth_pcs_rx_block_sync #(.W_DATA(66)) u66 (
    .i_clk(clk), .i_reset(rst), .i_pma_data(d66), .o_block_valid(v66),
    .o_block_header(h66), .o_block_data(dt66), .o_block_lock(l66), .o_slip(s66));

  int checks = 0;
  int fails  = 0;

  // Main-stream configuration: prefix zero bits, base header, zero/pattern
  // payload, two runs of invalid headers and one invalid block per window.
  int       prefix;
  logic [1:0] base_hdr;
  bit       zdata;
  int       per;
  int       b1s, b1n, b2s, b2n;

  int k32, k16, k64, k66;
  int strobes, slips, since_slip, rise_at, consec;
  bit prev_slip, lock_fell, prev_lock;
  int sw_n[3];
  bit sw_slip[3];
  int sw_w[3] = '{16, 64, 66};

  typedef struct {
    int       prefix;
    logic [1:0] hdr;
    bit       zdata;
    int       per;
    int       ncyc;
    int       exp_slips;
    int       exp_rise;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dat_of(input int b, input bit z);
    logic [31:0] bb;
    bb = 32'(b);
    if (z) return 64'h0;
    return {bb * 32'h9E37_79B9, bb ^ 32'hA5C3_0F1E};
  endfunction

  function automatic logic [1:0] main_hdr(input int b);
    if ((b >= b1s && b < b1s + b1n) || (b >= b2s && b < b2s + b2n) ||
        (per > 0 && b >= 64 && (b % per) == 10))
      return 2'b11;
    return base_hdr;
  endfunction

  function automatic logic main_bit(input int k);
    logic [1:0]  h;
    logic [63:0] d;
    int kk, b, p;
    if (k < prefix) return 1'b0;
    kk = k - prefix;
    b  = kk / 66;
    p  = kk % 66;
    if (p < 2) begin
      h = main_hdr(b);
      return h[p];
    end
    d = dat_of(b, zdata);
    return d[p-2];
  endfunction

  function automatic logic ref_bit(input int k);
    logic [1:0]  h;
    logic [63:0] d;
    int b, p;
    b = k / 66;
    p = k % 66;
    h = 2'b01;
    if (p < 2) return h[p];
    d = dat_of(b, 1'b0);
    return d[p-2];
  endfunction

  task automatic release_reset();
    rst = 1'b0;
    k32 = 0; k16 = 0; k64 = 0; k66 = 0;
    strobes = 0; slips = 0; since_slip = 0; rise_at = 0; consec = 0;
    prev_slip = 1'b0; lock_fell = 1'b0; prev_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sw_n[i]    = 0;
      sw_slip[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    release_reset();
  endtask

  task automatic sweep_mon(input int i, input logic v, input logic [1:0] h,
                           input logic [63:0] d, input logic l, input logic s);
    if (s) sw_slip[i] = 1'b1;
    if (v) begin
      chk($sformatf("w%0d_hdr", sw_w[i]), 64'(h), 64'(2'b01));
      chk($sformatf("w%0d_data", sw_w[i]), d, dat_of(sw_n[i], 1'b0));
      sw_n[i]++;
      chk($sformatf("w%0d_lock", sw_w[i]), 64'(l), 64'(sw_n[i] >= 64));
    end
  endtask

  // Drive one word into every instance, wait one edge, then monitor.
  task automatic cycle();
    for (int i = 0; i < 32; i++) d32[i] = main_bit(k32 + i);
    for (int i = 0; i < 16; i++) d16[i] = ref_bit(k16 + i);
    for (int i = 0; i < 64; i++) d64[i] = ref_bit(k64 + i);
    for (int i = 0; i < 66; i++) d66[i] = ref_bit(k66 + i);
    k32 += 32; k16 += 16; k64 += 64; k66 += 66;
    @(posedge clk);
    #1;
    if (s32) begin
      if (prev_slip) consec++;
      slips++;
      since_slip = 0;
    end
    prev_slip = s32;
    if (v32) begin
      since_slip++;
      if (slips == prefix && !lock_fell) begin
        chk("blk_hdr", 64'(h32), 64'(main_hdr(strobes)));
        chk("blk_data", dt32, dat_of(strobes, zdata));
      end
      strobes++;
    end
    if (l32 && !prev_lock) rise_at = since_slip;
    if (!l32 && prev_lock) lock_fell = 1'b1;
    prev_lock = l32;
    sweep_mon(0, v16, h16, dt16, l16, s16);
    sweep_mon(1, v64, h64, dt64, l64, s64);
    sweep_mon(2, v66, h66, dt66, l66, s66);
  endtask

  initial begin
    vec_t tbl[4];
    bit   seen_loss;
    int   j;

    tbl[0] = '{0, 2'b01, 1'b1, 0,  300,  0, 64};
    tbl[1] = '{5, 2'b10, 1'b1, 0,  400,  5, 64};
    tbl[2] = '{0, 2'b01, 1'b0, 0,  300,  0, 64};
    tbl[3] = '{0, 2'b01, 1'b0, 64, 2300, 0, 64};

    release_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int t = 0; t < 4; t++) begin
      prefix = tbl[t].prefix; base_hdr = tbl[t].hdr; zdata = tbl[t].zdata;
      per = tbl[t].per; b1s = 0; b1n = 0; b2s = 0; b2n = 0;
      do_reset();
      repeat (tbl[t].ncyc) cycle();
      chk($sformatf("t%0d_slips", t), 64'(slips), 64'(tbl[t].exp_slips));
      chk($sformatf("t%0d_lock_rise", t), 64'(rise_at), 64'(tbl[t].exp_rise));
      chk($sformatf("t%0d_lock_end", t), 64'(l32), 64'(1));
      chk($sformatf("t%0d_lock_held", t), 64'(lock_fell), 64'(0));
      chk($sformatf("t%0d_slip_consec", t), 64'(consec), 64'(0));
      chk($sformatf("t%0d_strobes", t), 64'(strobes),
          64'((32 * tbl[t].ncyc - tbl[t].exp_slips) / 66));
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t%0d_w%0d_cadence", t, sw_w[i]), 64'(sw_n[i]),
            64'((tbl[t].ncyc * sw_w[i]) / 66));
        chk($sformatf("t%0d_w%0d_noslip", t, sw_w[i]), 64'(sw_slip[i]), 64'(0));
      end
      $display("scenario %0d: %0d cycles, %0d strobes, %0d slips, lock rise at %0d",
               t, tbl[t].ncyc, strobes, slips, rise_at);
    end

    // Asynchronous reset while locked, then first-strobe latency after release.
    prefix = 0; base_hdr = 2'b01; zdata = 1'b0; per = 0;
    b1s = 0; b1n = 0; b2s = 0; b2n = 0;
    do_reset();
    repeat (150) cycle();
    chk("pre_reset_lock", 64'(l32), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(v32), 64'(0));
    chk("rst_header", 64'(h32), 64'(0));
    chk("rst_data", dt32, 64'(0));
    chk("rst_lock", 64'(l32), 64'(0));
    chk("rst_slip", 64'(s32), 64'(0));
    repeat (3) begin
      d32 = $urandom;
      @(posedge clk);
      #1;
      chk("rst_hold_valid", 64'(v32), 64'(0));
      chk("rst_hold_data", dt32, 64'(0));
    end
    release_reset();
    cycle();
    chk("lat_edge1_valid", 64'(v32), 64'(0));
    cycle();
    chk("lat_edge2_valid", 64'(v32), 64'(0));
    cycle();
    chk("lat_edge3_valid", 64'(v32), 64'(1));
    $display("reset sequence: first strobe after 3 edges, %0d strobes", strobes);

    // 15 invalid headers in one window keep lock; 16 in the next drop it.
    prefix = 0; base_hdr = 2'b01; zdata = 1'b0; per = 0;
    b1s = 64; b1n = 15; b2s = 130; b2n = 16;
    do_reset();
    seen_loss = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (v32) begin
        j = strobes - 1;
        if (j == 63)  chk("acq_lock", 64'(l32), 64'(1));
        if (j == 127) chk("retain_15", 64'(l32), 64'(1));
        if (j == 144) chk("before_16", 64'(l32), 64'(1));
        if (j == 145) begin
          seen_loss = 1'b1;
          chk("loss_16", 64'(l32), 64'(0));
          chk("loss_no_slip_yet", 64'(s32), 64'(0));
          cycle();
          chk("slip_after_loss", 64'(s32), 64'(1));
          $display("loss sequence: lock dropped at strobe %0d, slip next cycle", j + 1);
          break;
        end
      end
    end
    chk("loss_reached", 64'(seen_loss), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
